// File: rtl/euler_vec_stepper.sv
// Euler step engine: y[i] = sat(x[i] + h*f[i]) over dim elements, LANES per beat, RAM in / RAM out.
// Start-to-first-write latency 4 cycles; no backpressure, start is ignored while busy.
module euler_vec_stepper #(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16,
  parameter int FRAC_BITS = 8,
  parameter int MAX_DIM   = 6,
  parameter int LANES     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [DATA_SIZE-1:0]         h_step,
  input  logic [ADD_SIZE-1:0]          dim,
  input  logic [ADD_SIZE-1:0]          x_base,
  input  logic [ADD_SIZE-1:0]          f_base,
  input  logic [ADD_SIZE-1:0]          y_base,
  output logic [LANES*ADD_SIZE-1:0]    x_addr,
  input  logic [LANES*DATA_SIZE-1:0]   x_data,
  output logic [LANES*ADD_SIZE-1:0]    f_addr,
  input  logic [LANES*DATA_SIZE-1:0]   f_data,
  output logic [LANES-1:0]             wr_en,
  output logic [LANES*ADD_SIZE-1:0]    wr_addr,
  output logic [LANES*DATA_SIZE-1:0]   wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         sat,
  output logic                         err
);

  localparam int AW = ADD_SIZE;
  localparam int DW = DATA_SIZE;
  localparam int PW = 2 * DW + 1;
  localparam logic signed [PW-1:0] SMAX = PW'(2 ** (DW - 1) - 1);
  localparam logic signed [PW-1:0] SMIN = PW'(-(2 ** (DW - 1)));

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic                   drain_q, drain_d;
  logic                   err_q, err_d;
  logic                   sat_q;
  logic [DW-1:0]          h_q;
  logic [AW-1:0]          dim_q, x_base_q, f_base_q, y_base_q;
  logic [LANES*AW-1:0]    x_addr_q, f_addr_q;
  logic [LANES-1:0]       s1_vld_q;
  logic [LANES*AW-1:0]    s1_addr_q;
  logic [LANES-1:0]       wr_en_q;
  logic [LANES*AW-1:0]    wr_addr_q;
  logic [LANES*DW-1:0]    wr_data_q;

  logic                   accept;
  logic [LANES-1:0]       lane_act;
  logic [AW-1:0]          elem [LANES];

  logic signed [2*DW-1:0] prod [LANES];
  logic signed [2*DW-1:0] psh  [LANES];
  logic signed [PW-1:0]   sum  [LANES];
  logic [DW-1:0]          res  [LANES];
  logic [LANES-1:0]       clamp;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    drain_d  = drain_q;
    err_d    = err_q;
    accept   = 1'b0;
    lane_act = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // An illegal dim skips straight to a single drain cycle so done lands 3 cycles after start.
        if (dim_q == '0 || dim_q > AW'(MAX_DIM)) begin
          err_d   = 1'b1;
          drain_d = 1'b1;
          state_d = S_DRAIN;
        end else begin
          drain_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        for (int l = 0; l < LANES; l++) begin
          lane_act[l] = ({1'b0, idx_q} + (AW + 1)'(l)) < {1'b0, dim_q};
        end
        idx_d = idx_q + AW'(LANES);
        if (({1'b0, idx_q} + (AW + 1)'(LANES)) >= {1'b0, dim_q}) begin
          drain_d = 1'b0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Idle lanes hold their last address so the RAMs never see out-of-range reads.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      elem[l]             = idx_q + AW'(l);
      x_addr[l*AW +: AW]  = x_addr_q[l*AW +: AW];
      f_addr[l*AW +: AW]  = f_addr_q[l*AW +: AW];
      if (lane_act[l]) begin
        x_addr[l*AW +: AW] = x_base_q + elem[l];
        f_addr[l*AW +: AW] = f_base_q + elem[l];
      end
    end
  end

  always_comb begin
    clamp = '0;
    for (int l = 0; l < LANES; l++) begin
      prod[l] = (2 * DW)'($signed(f_data[l*DW +: DW])) * (2 * DW)'($signed(h_q));
      psh[l]  = prod[l] >>> FRAC_BITS;
      sum[l]  = PW'(psh[l]) + PW'($signed(x_data[l*DW +: DW]));
      res[l]  = sum[l][DW-1:0];
      if (sum[l] > SMAX) begin
        res[l]   = SMAX[DW-1:0];
        clamp[l] = 1'b1;
      end else if (sum[l] < SMIN) begin
        res[l]   = SMIN[DW-1:0];
        clamp[l] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      drain_q   <= 1'b0;
      err_q     <= 1'b0;
      sat_q     <= 1'b0;
      h_q       <= '0;
      dim_q     <= '0;
      x_base_q  <= '0;
      f_base_q  <= '0;
      y_base_q  <= '0;
      x_addr_q  <= '0;
      f_addr_q  <= '0;
      s1_vld_q  <= '0;
      s1_addr_q <= '0;
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
      x_addr_q <= x_addr;
      f_addr_q <= f_addr;
      if (accept) begin
        h_q      <= h_step;
        dim_q    <= dim;
        x_base_q <= x_base;
        f_base_q <= f_base;
        y_base_q <= y_base;
      end
      s1_vld_q <= lane_act;
      for (int l = 0; l < LANES; l++) begin
        s1_addr_q[l*AW +: AW] <= y_base_q + elem[l];
        wr_data_q[l*DW +: DW] <= res[l];
      end
      wr_en_q   <= s1_vld_q;
      wr_addr_q <= s1_addr_q;
      if (accept) sat_q <= 1'b0;
      else if (|(s1_vld_q & clamp)) sat_q <= 1'b1;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign sat     = sat_q;
  assign err     = err_q;

endmodule

// File: tb/tb_euler_vec_stepper.sv
// Bench for euler_vec_stepper: a LANES=2 and a LANES=1 instance sharing RAM models,
// with per-instance expected-write queues drained by a negedge monitor.
module tb_euler_vec_stepper;

  logic        clk = 1'b0;
  logic        rst, start0, start1;
  logic [15:0] h_step, dim, x_base, f_base, y_base;

  logic [31:0] x_addr0, f_addr0, x_data0, f_data0, wr_addr0, wr_data0;
  logic [1:0]  wr_en0;
  logic        busy0, done0, sat0, err0;

  logic [15:0] x_addr1, f_addr1, x_data1, f_data1, wr_addr1, wr_data1;
  logic        wr_en1;
  logic        busy1, done1, sat1, err1;

  logic [15:0] xm [256];
  logic [15:0] fm [256];

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]  en;
    logic [15:0] a0, d0, a1, d1;
  } beat_t;

  beat_t q0[$];
  beat_t q1[$];
  beat_t e0, e1;

  euler_vec_stepper #(.LANES(2)) u0 (
    .clk(clk), .rst(rst), .start(start0), .h_step(h_step), .dim(dim),
    .x_base(x_base), .f_base(f_base), .y_base(y_base),
    .x_addr(x_addr0), .x_data(x_data0), .f_addr(f_addr0), .f_data(f_data0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .busy(busy0), .done(done0), .sat(sat0), .err(err0)
  );

  euler_vec_stepper #(.LANES(1)) u1 (
    .clk(clk), .rst(rst), .start(start1), .h_step(h_step), .dim(dim),
    .x_base(x_base), .f_base(f_base), .y_base(y_base),
    .x_addr(x_addr1), .x_data(x_data1), .f_addr(f_addr1), .f_data(f_data1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .busy(busy1), .done(done1), .sat(sat1), .err(err1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM models
  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      x_data0[l*16 +: 16] <= xm[x_addr0[l*16 +: 8]];
      f_data0[l*16 +: 16] <= fm[f_addr0[l*16 +: 8]];
    end
    x_data1 <= xm[x_addr1[7:0]];
    f_data1 <= fm[f_addr1[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en0 != 2'b00) begin
      if (q0.size() == 0) chk("u0 unexpected write", {30'b0, wr_en0}, 32'h0);
      else begin
        e0 = q0.pop_front();
        chk("u0 wr_en", {30'b0, wr_en0}, {30'b0, e0.en});
        if (e0.en[0]) begin
          chk("u0 lane0 addr", {16'b0, wr_addr0[15:0]}, {16'b0, e0.a0});
          chk("u0 lane0 data", {16'b0, wr_data0[15:0]}, {16'b0, e0.d0});
        end
        if (e0.en[1]) begin
          chk("u0 lane1 addr", {16'b0, wr_addr0[31:16]}, {16'b0, e0.a1});
          chk("u0 lane1 data", {16'b0, wr_data0[31:16]}, {16'b0, e0.d1});
        end
      end
    end
    if (wr_en1) begin
      if (q1.size() == 0) chk("u1 unexpected write", {31'b0, wr_en1}, 32'h0);
      else begin
        e1 = q1.pop_front();
        chk("u1 addr", {16'b0, wr_addr1}, {16'b0, e1.a0});
        chk("u1 data", {16'b0, wr_data1}, {16'b0, e1.d0});
      end
    end
  end

  task automatic run(input bit sel, input logic [15:0] d, input logic [15:0] h,
                     input logic [15:0] b, input int lat, input logic exp_err,
                     input logic exp_sat, input string name);
    int  t0;
    bit  seen;
    @(posedge clk); #1;
    dim = d; h_step = h; x_base = b; f_base = b; y_base = b + 16'h0080;
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    dim = 16'hFFFF; h_step = 16'h1234; x_base = 16'h00EE; f_base = 16'h00EE; y_base = 16'h00EE;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (sel ? done1 : done0) begin
        seen = 1'b1;
        chk({name, " done latency"}, cyc - t0, lat);
        chk({name, " err"}, {31'b0, sel ? err1 : err0}, {31'b0, exp_err});
        chk({name, " sat"}, {31'b0, sel ? sat1 : sat0}, {31'b0, exp_sat});
      end
    end
    if (!seen) chk({name, " done timeout"}, 32'h0, 32'h1);
    @(negedge clk);
    chk({name, " busy after done"}, {31'b0, sel ? busy1 : busy0}, 32'h0);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      xm[i] = 16'h0;
      fm[i] = 16'h0;
    end
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    h_step = '0; dim = '0; x_base = '0; f_base = '0; y_base = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset busy", {31'b0, busy0}, 32'h0);
    chk("reset done", {31'b0, done0}, 32'h0);
    chk("reset sat", {31'b0, sat0}, 32'h0);
    chk("reset err", {31'b0, err0}, 32'h0);
    chk("reset wr_en", {30'b0, wr_en0}, 32'h0);
    chk("reset x_addr", x_addr0, 32'h0);

    // T1: 0x0100 + 0.5*2.0
    xm[8'h00] = 16'h0100; fm[8'h00] = 16'h0200;
    q0.push_back({2'b01, 16'h0080, 16'h0200, 16'h0, 16'h0});
    run(1'b0, 16'd1, 16'h0080, 16'h0000, 5, 1'b0, 1'b0, "T1");

    // T2: dim=5, odd tail beat uses only lane 0
    for (int i = 0; i < 6; i++) begin
      xm[8'h10 + i] = 16'(i << 8);
      fm[8'h10 + i] = 16'h0100;
    end
    q0.push_back({2'b11, 16'h0090, 16'h0100, 16'h0091, 16'h0200});
    q0.push_back({2'b11, 16'h0092, 16'h0300, 16'h0093, 16'h0400});
    q0.push_back({2'b01, 16'h0094, 16'h0500, 16'h0, 16'h0});
    run(1'b0, 16'd5, 16'h0100, 16'h0010, 7, 1'b0, 1'b0, "T2");

    // dim = MAX_DIM is legal
    q0.push_back({2'b11, 16'h0090, 16'h0100, 16'h0091, 16'h0200});
    q0.push_back({2'b11, 16'h0092, 16'h0300, 16'h0093, 16'h0400});
    q0.push_back({2'b11, 16'h0094, 16'h0500, 16'h0095, 16'h0600});
    run(1'b0, 16'd6, 16'h0100, 16'h0010, 7, 1'b0, 1'b0, "dim6");

    // T3: positive clamp on lane 0, negative clamp on lane 1
    xm[8'h20] = 16'h7F00; fm[8'h20] = 16'h7F00;
    xm[8'h21] = 16'h8000; fm[8'h21] = 16'h8000;
    q0.push_back({2'b11, 16'h00A0, 16'h7FFF, 16'h00A1, 16'h8000});
    run(1'b0, 16'd2, 16'h0100, 16'h0020, 5, 1'b0, 1'b1, "T3");

    // T4: negative products, floor shift of -1 stays -1; sat clears on new start
    xm[8'h30] = 16'h0000; fm[8'h30] = 16'hFF00;
    q0.push_back({2'b01, 16'h00B0, 16'hFF80, 16'h0, 16'h0});
    run(1'b0, 16'd1, 16'h0080, 16'h0030, 5, 1'b0, 1'b0, "T4a");
    xm[8'h38] = 16'h0000; fm[8'h38] = 16'hFFFF;
    q0.push_back({2'b01, 16'h00B8, 16'hFFFF, 16'h0, 16'h0});
    run(1'b0, 16'd1, 16'h0001, 16'h0038, 5, 1'b0, 1'b0, "T4b");

    // T5: illegal dims produce err and no writes; a legal start clears err
    run(1'b0, 16'd0, 16'h0100, 16'h0050, 3, 1'b1, 1'b0, "T5 dim0");
    run(1'b0, 16'd7, 16'h0100, 16'h0050, 3, 1'b1, 1'b0, "T5 dim7");
    q0.push_back({2'b01, 16'h0080, 16'h0200, 16'h0, 16'h0});
    run(1'b0, 16'd1, 16'h0080, 16'h0000, 5, 1'b0, 1'b0, "T5 clear");

    // T6: reset in cycle 3 of a dim=6 run aborts before any write
    @(posedge clk); #1;
    dim = 16'd6; h_step = 16'h0100; x_base = 16'h0010; f_base = 16'h0010; y_base = 16'h0090;
    start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("T6 busy before reset", {31'b0, busy0}, 32'h1);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("T6 busy after reset", {31'b0, busy0}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk("T6 wr_en after reset", {30'b0, wr_en0}, 32'h0);
      @(negedge clk);
    end

    // T2 on the single-lane instance
    for (int i = 0; i < 5; i++) q1.push_back({2'b01, 16'(16'h0090 + i), 16'((i + 1) << 8), 16'h0, 16'h0});
    run(1'b1, 16'd5, 16'h0100, 16'h0010, 9, 1'b0, 1'b0, "T2 lanes1");

    repeat (4) @(posedge clk);
    chk("u0 pending writes", q0.size(), 32'h0);
    chk("u1 pending writes", q1.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
